spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
- SPI mode-0 responder emulating a serial flash READ target for the flash-reader master on the same bus.
- Decodes command byte 0x03 plus a 24-bit address MSB-first, then streams bytes from an on-chip byte store out on MISO, auto-incrementing the address until chip-select deasserts.
- Sits between the SPI pins and a ROM/BRAM read port.
- Lets the C64 boot/loader path be simulated and run without an external flash part.

Parameters:
- ADDR_W, 16, width of mem_addr; the low ADDR_W bits of the 24-bit internal address are used.
- SYNC_STAGES, 2, synchronizer depth on spi_sclk, spi_cs_n and spi_mosi (legal values 2 or 3).

Ports:
- clk  input  1  system clock; must be at least 8x the SCLK frequency.
- reset  input  1  synchronous, active-low.
- spi_sclk  input  1  SPI clock from the master, idle low.
- spi_cs_n  input  1  chip select, active-low.
- spi_mosi  input  1  serial data from the master.
- spi_miso  output  1  serial data to the master.
- spi_miso_oe  output  1  MISO output enable; 1 only while the responder is in DATA.
- mem_addr  output  ADDR_W  byte address to the store.
- mem_req  output  1  read request, level, held until ack.
- mem_ack  input  1  one-cycle strobe; mem_data is valid in the same cycle.
- mem_data  input  8  read data.
- busy  output  1  1 whenever the synchronized CS is active.
- cmd_error  output  1  one-cycle pulse when an unsupported command byte is received.
- underrun  output  1  sticky flag; cleared on CS assertion.

Behaviour:
- Reset (reset=0 at a clk edge) gives these values:
  - spi_miso=1, spi_miso_oe=0.
  - mem_req=0, mem_addr=0.
  - busy=0, cmd_error=0, underrun=0.
  - State=IDLE; bit counter and shift registers cleared.
- Reset asserted mid-transfer aborts immediately to the reset values.
- Input sampling:
  - All three inputs pass through SYNC_STAGES flops.
  - rise = synchronized SCLK 0->1; fall = synchronized SCLK 1->0.
  - Each is a one-cycle pulse, detected in clk.
- Mode 0 timing: MOSI is sampled on rise. MISO changes only on fall.
- State IDLE:
  - On synchronized CS falling, go to CMD, clear underrun, and set bit counter=0.
- State CMD:
  - Shift 8 MOSI bits in, MSB first.
  - On the 8th rise: 0x03 goes to ADDR. Any other value pulses cmd_error and goes to IGNORE.
- State ADDR:
  - Shift 24 bits in, MSB first.
  - On the 24th rise, load the address counter and assert mem_req with mem_addr = addr[ADDR_W-1:0].
  - Go to DATA.
- State DATA:
  - On mem_ack, capture mem_data into the holding register and set hold_valid.
  - Drop mem_req in the cycle after ack.
  - On each fall at bit index 0: if hold_valid, move holding to the tx shifter, clear hold_valid, increment the address, and issue the next mem_req (prefetch). Otherwise load 0xFF and set underrun.
  - On other falls, shift the tx shifter left. spi_miso = tx[7].
  - The bit index is mod 8 and advances on rise.
  - spi_miso_oe=1 throughout DATA.
- State IGNORE:
  - MISO is held at 1 with oe=0.
  - All SCLK activity is ignored until CS deasserts.
- CS deasserts (synchronized 0->1) in any state:
  - Go to IDLE in the next cycle.
  - Set oe=0 and miso=1.
  - Drop mem_req; a pending ack arriving later is discarded.
  - A partial byte is abandoned.
- Address counter:
  - 24-bit, wraps 0xFFFFFF -> 0x000000.
  - mem_addr wraps at 2^ADDR_W naturally.
- Memory latency budget:
  - The first byte must be acked within 3 clk cycles of mem_req, so it arrives before the first data fall at the 8x ratio.
  - Prefetched bytes have 7 SCLK periods of slack.
- Simultaneous events:
  - CS deassert has priority over rise/fall.
  - mem_ack in the same cycle as a byte-boundary fall: the fresh data is used directly and underrun is not set.

Optional Feature:
- Macro: SPI_RESP_FAST_READ_EN.
- When defined, command 0x0B is also accepted: after the 24 address bits, the block consumes 8 dummy clocks (state DUMMY, MISO oe=0), then enters DATA exactly as for 0x03. The first mem_req is issued at the end of ADDR, which leaves extra latency slack.
- When undefined, 0x0B is treated as an unsupported command: cmd_error pulses and the block goes to IGNORE.

Test Plan:
- Reset check: hold reset=0 for 4 cycles mid-transfer -> miso=1, oe=0, mem_req=0, busy=0 in the cycle after the reset edge.
- Basic read: store[0x0000..0x0003] = A5,3C,FF,01; master sends 03 00 00 00 followed by 32 clocks -> MISO yields A5 3C FF 01; mem_addr requests 0,1,2,3,4; underrun=0.
- Wrap-around: with ADDR_W=16, read at 0x00FFFF for 2 bytes -> mem_addr 0xFFFF then 0x0000; bytes store[0xFFFF], store[0x0000].
- Bad command: send 0x9F 00 00 -> one cmd_error pulse; oe stays 0 and mem_req stays 0 until CS high.
- Underrun: stall mem_ack for 20 SCLK periods after the address -> first byte FF, underrun=1; the next CS assertion clears underrun.
- Abort: raise CS after 3 data bits of byte 0 -> IDLE within SYNC_STAGES+2 cycles; a new 03 transaction at address 0x10 returns store[0x10] correctly.

Source files
------------

// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: SPI pins plus byte-store read port of the flash responder
interface spi_flash_responder_if #(parameter int ADDR_W = 16);
   logic spi_sclk, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;
   logic [ADDR_W-1:0] mem_addr;
   logic mem_req, mem_ack;
   logic [7:0] mem_data;
   modport slave (input spi_sclk, spi_cs_n, spi_mosi, mem_ack, mem_data,
                  output spi_miso, spi_miso_oe, mem_addr, mem_req);
   modport master (output spi_sclk, spi_cs_n, spi_mosi, mem_ack, mem_data,
                   input spi_miso, spi_miso_oe, mem_addr, mem_req);
endinterface

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 READ (0x03) flash target streaming bytes from a store read port
// Defining SPI_RESP_FAST_READ_EN also accepts FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_responder #(
   parameter int ADDR_W = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   spi_flash_responder_if.slave bus,
   output logic busy,
   output logic cmd_error,
   output logic underrun
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
   state_t state, state_n, addr_next;
   logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
   logic sclk_q, cs_q, sclk_s, cs_s, mosi_s;
   logic rise, fall, cs_fall, cs_rise, last_bit, cmd_ok, ack, byte_fall, avail;
   logic [4:0] bit_cnt;
   logic [22:0] shift_in;
   logic [23:0] addr_in, addr_cnt, addr_inc;
   logic [7:0] cmd, hold, tx;
   logic hold_valid;
`ifdef SPI_RESP_FAST_READ_EN
   logic fast;
   assign cmd_ok = cmd == 8'h03 || cmd == 8'h0B;
   assign addr_next = fast ? DUMMY : DATA;
`else
   assign cmd_ok = cmd == 8'h03;
   assign addr_next = DATA;
`endif
   assign sclk_s = sclk_sr[SYNC_STAGES-1];
   assign cs_s = cs_sr[SYNC_STAGES-1];
   assign mosi_s = mosi_sr[SYNC_STAGES-1];
   assign rise = sclk_s & ~sclk_q;
   assign fall = ~sclk_s & sclk_q;
   assign cs_fall = ~cs_s & cs_q;
   assign cs_rise = cs_s & ~cs_q;
   assign cmd = {shift_in[6:0], mosi_s};
   assign addr_in = {shift_in, mosi_s};
   assign addr_inc = addr_cnt + 24'd1;
   assign last_bit = rise && bit_cnt == (state == ADDR ? 5'd23 : 5'd7);
   assign ack = bus.mem_req & bus.mem_ack;
   assign byte_fall = state == DATA && fall && bit_cnt[2:0] == 3'd0 && !cs_rise;
   assign avail = hold_valid | ack;
   assign busy = ~cs_s;
   assign bus.spi_miso_oe = state == DATA;
   assign bus.spi_miso = state == DATA ? tx[7] : 1'b1;

   always_comb begin
      state_n = state;
      if (cs_rise) state_n = IDLE;
      else case (state)
         IDLE:  state_n = cs_fall ? CMD : IDLE;
         CMD:   state_n = last_bit ? (cmd_ok ? ADDR : IGNORE) : CMD;
         ADDR:  state_n = last_bit ? addr_next : ADDR;
         DUMMY: state_n = last_bit ? DATA : DUMMY;
         default: state_n = state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         sclk_sr <= '0;
         cs_sr <= '1;
         mosi_sr <= '0;
         sclk_q <= 1'b0;
         cs_q <= 1'b1;
         bit_cnt <= '0;
         shift_in <= '0;
         addr_cnt <= '0;
         hold <= '0;
         hold_valid <= 1'b0;
         tx <= 8'hFF;
         bus.mem_req <= 1'b0;
         bus.mem_addr <= '0;
         cmd_error <= 1'b0;
         underrun <= 1'b0;
`ifdef SPI_RESP_FAST_READ_EN
         fast <= 1'b0;
`endif
      end else begin
         state <= state_n;
         sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], bus.spi_sclk};
         cs_sr <= {cs_sr[SYNC_STAGES-2:0], bus.spi_cs_n};
         mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], bus.spi_mosi};
         sclk_q <= sclk_s;
         cs_q <= cs_s;
         cmd_error <= state == CMD && last_bit && !cmd_ok && !cs_rise;
         if (rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            shift_in <= {shift_in[21:0], mosi_s};
         end
         if (state_n != state) bit_cnt <= '0;
         if (state == IDLE && state_n == CMD) underrun <= 1'b0;
`ifdef SPI_RESP_FAST_READ_EN
         if (state == CMD && last_bit) fast <= cmd == 8'h0B;
`endif
         // first fetch goes out at the end of ADDR so DUMMY clocks add slack
         if (state == ADDR && last_bit && !cs_rise) begin
            addr_cnt <= addr_in;
            bus.mem_addr <= addr_in[ADDR_W-1:0];
            bus.mem_req <= 1'b1;
            hold_valid <= 1'b0;
            tx <= 8'hFF;
         end
         if (ack) begin
            hold <= bus.mem_data;
            hold_valid <= 1'b1;
            bus.mem_req <= 1'b0;
         end
         if (byte_fall) begin
            if (avail) begin
               tx <= hold_valid ? hold : bus.mem_data;
               hold_valid <= 1'b0;
               addr_cnt <= addr_inc;
               bus.mem_addr <= addr_inc[ADDR_W-1:0];
               bus.mem_req <= 1'b1;
            end else begin
               tx <= 8'hFF;
               underrun <= 1'b1;
            end
         end else if (state == DATA && fall) tx <= {tx[6:0], 1'b1};
         if (cs_rise) begin
            bus.mem_req <= 1'b0;
            hold_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: random READ transactions against a flat byte-array flash model
module tb_spi_flash_responder;
   localparam int AW = 16;
   logic clk = 1'b0, reset = 1'b0;
   logic busy, cmd_error, underrun;
   logic stall = 1'b0;
   int checks = 0, errors = 0;
   int half = 4, lat = 0;
   int err_pulses = 0, oe_cycles = 0, req_cycles = 0;
   logic [7:0] store [0:(1<<AW)-1];
   logic [7:0] rx[$];
   logic [AW-1:0] served[$];

   spi_flash_responder_if #(.ADDR_W(AW)) bus();
   spi_flash_responder #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .busy(busy), .cmd_error(cmd_error), .underrun(underrun));

   always #5 clk = ~clk;

   // memory answers each request after 1..3 cycles unless stalled
   always @(negedge clk) begin
      bus.mem_ack = 1'b0;
      if (bus.mem_req && !stall) begin
         if (lat == 0) begin
            bus.mem_ack = 1'b1;
            bus.mem_data = store[bus.mem_addr];
            served.push_back(bus.mem_addr);
            lat = $urandom_range(0, 2);
         end else lat--;
      end
   end

   always @(negedge clk) begin
      if (cmd_error) err_pulses++;
      if (bus.spi_miso_oe) oe_cycles++;
      if (bus.mem_req) req_cycles++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic spi_bits(input logic [7:0] out, input int n, output logic [7:0] in);
      in = 8'h00;
      for (int i = 7; i >= 8 - n; i--) begin
         bus.spi_mosi = out[i];
         repeat (half) @(negedge clk);
         in[i] = bus.spi_miso;
         bus.spi_sclk = 1'b1;
         repeat (half) @(negedge clk);
         bus.spi_sclk = 1'b0;
      end
   endtask

   task automatic cs_assert();
      @(negedge clk);
      bus.spi_cs_n = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_release();
      repeat (2) @(negedge clk);
      bus.spi_cs_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic send_header(input logic [7:0] c, input logic [23:0] a);
      logic [7:0] b;
      spi_bits(c, 8, b);
      spi_bits(a[23:16], 8, b);
      spi_bits(a[15:8], 8, b);
      spi_bits(a[7:0], 8, b);
   endtask

   task automatic read_xact(input logic [7:0] c, input logic [23:0] a, input int n);
      logic [7:0] b;
      int e0, o0, r0;
      logic [AW-1:0] ea;
      e0 = err_pulses; o0 = oe_cycles; r0 = req_cycles;
      served.delete();
      rx.delete();
      half = $urandom_range(4, 6);
      cs_assert();
      check("underrun_clear", underrun, 0);
      check("busy_cs_low", busy, 1);
      send_header(c, a);
      for (int i = 0; i < n; i++) begin
         spi_bits(8'($urandom), 8, b);
         rx.push_back(b);
      end
      cs_release();
      check("busy_cs_high", busy, 0);
      if (c == 8'h03) begin
         check("cmd_err_none", err_pulses - e0, 0);
         check("underrun_none", underrun, 0);
         for (int i = 0; i < n; i++) begin
            ea = AW'(a + 24'(i));
            check("rx_byte", rx[i], store[ea]);
            check("req_addr", i < served.size() ? 32'(served[i]) : 32'hDEADBEEF, 32'(ea));
         end
      end else begin
         check("cmd_err_one", err_pulses - e0, 1);
         check("oe_bad_cmd", oe_cycles - o0, 0);
         check("req_bad_cmd", req_cycles - r0, 0);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] b, c;
      logic [23:0] a;
      bus.spi_sclk = 1'b0; bus.spi_cs_n = 1'b1; bus.spi_mosi = 1'b0;
      bus.mem_ack = 1'b0; bus.mem_data = 8'h00;
      for (int i = 0; i < (1 << AW); i++) store[i] = 8'($urandom);
      store[0] = 8'hA5; store[1] = 8'h3C; store[2] = 8'hFF; store[3] = 8'h01;
      repeat (3) @(negedge clk);
      check("rst_miso", bus.spi_miso, 1);
      check("rst_oe", bus.spi_miso_oe, 0);
      check("rst_req", bus.mem_req, 0);
      check("rst_addr", 32'(bus.mem_addr), 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_err", cmd_error, 0);
      check("rst_underrun", underrun, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      read_xact(8'h03, 24'h000000, 4);
      check("basic_req4", served.size() > 4 ? 32'(served[4]) : 32'hDEADBEEF, 4);
      read_xact(8'h03, 24'h00FFFF, 2);
      read_xact(8'h9F, 24'h000000, 1);

      // underrun: memory stalled across three byte slots
      stall = 1'b1;
      half = 4;
      cs_assert();
      send_header(8'h03, 24'h000020);
      for (int i = 0; i < 3; i++) begin
         spi_bits(8'h00, 8, b);
         check("underrun_byte", b, 8'hFF);
      end
      cs_release();
      check("underrun_set", underrun, 1);
      stall = 1'b0;
      read_xact(8'h03, 24'h000020, 2);

      // abort after three data bits, then restart at 0x10
      cs_assert();
      send_header(8'h03, 24'h000010);
      spi_bits(8'h00, 3, b);
      check("abort_partial", b[7:5], store[16'h0010][7:5]);
      bus.spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_oe", bus.spi_miso_oe, 0);
      check("abort_busy", busy, 0);
      check("abort_req", bus.mem_req, 0);
      repeat (4) @(negedge clk);
      read_xact(8'h03, 24'h000010, 2);

      // reset in the middle of a data byte
      cs_assert();
      send_header(8'h03, 24'h000100);
      spi_bits(8'h00, 4, b);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_miso", bus.spi_miso, 1);
      check("midrst_oe", bus.spi_miso_oe, 0);
      check("midrst_req", bus.mem_req, 0);
      check("midrst_busy", busy, 0);
      repeat (3) @(negedge clk);
      bus.spi_cs_n = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      for (int t = 0; t < 10; t++) begin
         case ($urandom_range(0, 2))
            0: a = 24'($urandom);
            1: a = 24'hFFFFFE;
            default: a = {8'($urandom), 16'hFFFE};
         endcase
         c = 8'h03;
         if ($urandom_range(0, 3) == 0)
            do c = 8'($urandom); while (c == 8'h03 || c == 8'h0B);
         read_xact(c, a, $urandom_range(1, 4));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
